// File: rtl/sar_pkg.sv
// Shared definitions for the SAR phase generator: FSM encoding, default sizes and width helpers.
package sar_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_SETTLE,
      ST_LATCH,
      ST_DONE
   } sar_state_e;

   localparam int unsigned N_DEF          = 8;
   localparam int unsigned SAMPLE_CYC_DEF = 2;
   localparam int unsigned SETTLE_W_DEF   = 2;

   // bit_idx width; a 1-bit converter still needs a 1-bit index
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Phase counter must hold both SAMPLE_CYC-1 and the largest settle_cfg value
   function automatic int unsigned cnt_w(input int unsigned sample_cyc,
                                         input int unsigned settle_w);
      int unsigned w;
      w = $clog2(sample_cyc);
      if (settle_w > w) w = settle_w;
      if (w < 1) w = 1;
      return w;
   endfunction

   localparam int unsigned IDX_W_DEF = idx_w(N_DEF);
   localparam int unsigned CNT_W_DEF = cnt_w(SAMPLE_CYC_DEF, SETTLE_W_DEF);

endpackage

// File: rtl/sar_phase_gen_if.sv
// Control and phase-output bundle between a conversion requester and the SAR phase generator.
interface sar_phase_gen_if #(
   parameter int unsigned N        = sar_pkg::N_DEF,
   parameter int unsigned SETTLE_W = sar_pkg::SETTLE_W_DEF
) ();
   localparam int unsigned IDX_W = sar_pkg::idx_w(N);

   logic                start;
   logic                abort;
   logic                cont_mode;
   logic [SETTLE_W-1:0] settle_cfg;
   logic                clk_samp;
   logic                bit_strobe;
   logic [IDX_W-1:0]    bit_idx;
   logic                busy;
   logic                done;

   modport master (
      output start, abort, cont_mode, settle_cfg,
      input  clk_samp, bit_strobe, bit_idx, busy, done
   );

   modport slave (
      input  start, abort, cont_mode, settle_cfg,
      output clk_samp, bit_strobe, bit_idx, busy, done
   );
endinterface

// File: rtl/sar_cycle_counter.sv
// Loadable down-counter with zero flag; times both the sample and settle phases.
module sar_cycle_counter #(
   parameter int unsigned W = sar_pkg::CNT_W_DEF
) (
   input  logic         clk_in,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero_c
);
   logic [W-1:0] count_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - W'(1);
      end
   end

   assign zero_c = (count_q == '0);
endmodule

// File: rtl/sar_phase_gen.sv
// SAR ADC phase generator: sample window, per-bit settle/latch sequencing and end-of-conversion pulse.
module sar_phase_gen
   import sar_pkg::*;
#(
   parameter int unsigned N          = N_DEF,
   parameter int unsigned SAMPLE_CYC = SAMPLE_CYC_DEF,
   parameter int unsigned SETTLE_W   = SETTLE_W_DEF
) (
   input logic            clk_in,
   input logic            rst_n,
   sar_phase_gen_if.slave bus
);
   localparam int unsigned IDX_W = idx_w(N);
   localparam int unsigned CNT_W = cnt_w(SAMPLE_CYC, SETTLE_W);

   localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(N - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYC - 1);

   sar_state_e          state_q, state_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                clk_samp_q, strobe_q, done_q, busy_q;

   logic                cnt_clr_c, cnt_load_c, cnt_zero_c;
   logic [CNT_W-1:0]    cnt_val_c;

   sar_cycle_counter #(.W(CNT_W)) u_cnt (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .clr      (cnt_clr_c),
      .load     (cnt_load_c),
      .load_val (cnt_val_c),
      .zero_c   (cnt_zero_c)
   );

   // Next-state logic; abort overrides every other transition out of a busy state
   always_comb begin
      state_d    = state_q;
      settle_d   = settle_q;
      idx_d      = idx_q;
      cnt_clr_c  = 1'b0;
      cnt_load_c = 1'b0;
      cnt_val_c  = SAMPLE_LOAD;

      if (state_q != ST_IDLE && bus.abort) begin
         state_d   = ST_IDLE;
         cnt_clr_c = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_d    = ST_SAMPLE;
                  settle_d   = bus.settle_cfg;
                  cnt_load_c = 1'b1;
               end
            end
            ST_SAMPLE: begin
               if (cnt_zero_c) begin
                  state_d    = ST_SETTLE;
                  idx_d      = IDX_MSB;
                  cnt_load_c = 1'b1;
                  cnt_val_c  = CNT_W'(settle_q);
               end
            end
            ST_SETTLE: begin
               if (cnt_zero_c) state_d = ST_LATCH;
            end
            ST_LATCH: begin
               if (idx_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d    = ST_SETTLE;
                  idx_d      = idx_q - IDX_W'(1);
                  cnt_load_c = 1'b1;
                  cnt_val_c  = CNT_W'(settle_q);
               end
            end
            ST_DONE: begin
               if (bus.cont_mode) begin
                  state_d    = ST_SAMPLE;
                  cnt_load_c = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they align with the state they describe
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         settle_q   <= '0;
         idx_q      <= '0;
         clk_samp_q <= 1'b0;
         strobe_q   <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         idx_q      <= idx_d;
         clk_samp_q <= (state_d == ST_SAMPLE);
         strobe_q   <= (state_d == ST_LATCH);
         done_q     <= (state_d == ST_DONE);
         busy_q     <= (state_d != ST_IDLE);
      end
   end

   assign bus.clk_samp   = clk_samp_q;
   assign bus.bit_strobe = strobe_q;
   assign bus.bit_idx    = idx_q;
   assign bus.done       = done_q;
   assign bus.busy       = busy_q;
endmodule
